// File: rtl/rd_xfr_ctrl_pkg.sv
// Shared definitions for the RD transfer controller: state encodings,
// STATUS bit positions, default parameters and a saturating increment.
package rd_xfr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_XFR   = 3'd3,
        ST_FIN   = 3'd4
    } xfr_state_t;

    localparam int STAT_START_TMO = 15;
    localparam int STAT_XFR_TMO   = 14;
    localparam int STAT_SHORT     = 13;
    localparam int STAT_OVERRUN   = 12;

    localparam int DEF_XFR_WORDS = 2048;
    localparam int DEF_START_LEN = 4;
    localparam int DEF_START_TMO = 4096;
    localparam int DEF_XFR_TMO   = 65535;
    localparam int DEF_QDEPTH    = 4;

    localparam int WCNT_W = 12;
    localparam int TMO_W  = 16;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rd_trig_fifo.sv
// Pending shower-trigger queue: small show-ahead FIFO of SDE buffer numbers.
// A pop is honoured together with a push even when the queue is full.
module rd_trig_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   cnt_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt_reg == '0);
    assign full    = (cnt_reg == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_reg <= cnt_reg + (AW+1)'(1);
                2'b01:   cnt_reg <= cnt_reg - (AW+1)'(1);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

endmodule

// File: rtl/rd_xfr_ctrl.sv
// RD transfer sequencer: pops queued triggers, requests a transfer, gates the
// word receiver while busy, supervises it with timeouts and reports DONE/STATUS.
module rd_xfr_ctrl
    import rd_xfr_ctrl_pkg::*;
#(
    parameter int XFR_WORDS = DEF_XFR_WORDS,
    parameter int START_LEN = DEF_START_LEN,
    parameter int START_TMO = DEF_START_TMO,
    parameter int XFR_TMO   = DEF_XFR_TMO,
    parameter int QDEPTH    = DEF_QDEPTH
) (
    input  logic        CLK120,
    input  logic        RESETN,
    input  logic        ENABLE,
    input  logic        TRIGGER,
    input  logic [1:0]  TRIG_BUF,
    input  logic        RD_BUSY,
    input  logic        WORD_STB,
    input  logic        PARITY_ERR,
    output logic        XFR_START,
    output logic [1:0]  XFR_BUF,
    output logic        RCV_EN,
    output logic        DONE,
    output logic [15:0] STATUS,
    output logic [7:0]  PERR_CNT,
    output logic [7:0]  DROP_CNT
);
    // The start timeout runs from START entry, but the counter restarts in WAIT,
    // so the WAIT limit is shortened by the START pulse length.
    localparam logic [TMO_W-1:0] START_LAST = TMO_W'(START_LEN - 1);
    localparam logic [TMO_W-1:0] WAIT_LAST  = TMO_W'(START_TMO - START_LEN - 1);
    localparam logic [TMO_W-1:0] XFR_LAST   = TMO_W'(XFR_TMO - 1);
    localparam logic [WCNT_W:0]  WORDS_MAX  = (WCNT_W+1)'(XFR_WORDS);

    xfr_state_t        state_reg;
    xfr_state_t        state_next;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic [WCNT_W-1:0] word_cnt_reg;
    logic [WCNT_W-1:0] words_upd;
    logic [7:0]        perr_cnt_reg;
    logic [7:0]        perr_upd;
    logic [7:0]        perr_out_reg;
    logic [7:0]        drop_cnt_reg;
    logic              ovr_reg;
    logic              ovr_upd;
    logic [1:0]        xfr_buf_reg;
    logic [15:0]       status_reg;
    logic [15:0]       status_next;
    logic              load_status;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_dout;
    logic              in_xfr;
    logic              word_take;

    assign fifo_push = TRIGGER & ENABLE;

    rd_trig_fifo #(
        .DEPTH (QDEPTH),
        .W     (2)
    ) u_trig_fifo (
        .clk   (CLK120),
        .rst_n (RESETN),
        .flush (~ENABLE),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (TRIG_BUF),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_xfr    = (state_reg == ST_XFR);
    assign word_take = in_xfr && WORD_STB && ({1'b0, word_cnt_reg} < WORDS_MAX)
                       && (word_cnt_reg != '1);
    assign words_upd = word_cnt_reg + WCNT_W'(word_take);
    assign ovr_upd   = ovr_reg | (in_xfr & WORD_STB & ~word_take);
    assign perr_upd  = (in_xfr && WORD_STB && PARITY_ERR) ? sat_inc8(perr_cnt_reg) : perr_cnt_reg;

    always_comb begin
        state_next  = state_reg;
        fifo_pop    = 1'b0;
        load_status = 1'b0;
        status_next = status_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tmo_cnt_reg == START_LAST) begin
                    state_next = RD_BUSY ? ST_XFR : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (RD_BUSY) begin
                    state_next = ST_XFR;
                end else if (tmo_cnt_reg == WAIT_LAST) begin
                    state_next                  = ST_FIN;
                    load_status                 = 1'b1;
                    status_next                 = '0;
                    status_next[STAT_START_TMO] = 1'b1;
                    status_next[WCNT_W-1:0]     = word_cnt_reg;
                end
            end
            ST_XFR: begin
                // Timeout is checked first so it wins over a coincident busy fall.
                if (tmo_cnt_reg == XFR_LAST || !RD_BUSY) begin
                    state_next                = ST_FIN;
                    load_status               = 1'b1;
                    status_next               = '0;
                    status_next[WCNT_W-1:0]   = words_upd;
                    status_next[STAT_OVERRUN] = ovr_upd;
                    if (tmo_cnt_reg == XFR_LAST) begin
                        status_next[STAT_XFR_TMO] = 1'b1;
                    end else begin
                        status_next[STAT_SHORT] = ({1'b0, words_upd} < WORDS_MAX);
                    end
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (!ENABLE) begin
            state_next  = ST_IDLE;
            fifo_pop    = 1'b0;
            load_status = 1'b0;
            status_next = status_reg;
        end
    end

    always_ff @(posedge CLK120 or negedge RESETN) begin
        if (!RESETN) begin
            state_reg    <= ST_IDLE;
            tmo_cnt_reg  <= '0;
            word_cnt_reg <= '0;
            perr_cnt_reg <= '0;
            perr_out_reg <= '0;
            drop_cnt_reg <= '0;
            ovr_reg      <= 1'b0;
            xfr_buf_reg  <= '0;
            status_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg || state_reg == ST_IDLE) begin
                tmo_cnt_reg <= '0;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            end
            if (fifo_pop) begin
                word_cnt_reg <= '0;
                perr_cnt_reg <= '0;
                ovr_reg      <= 1'b0;
                xfr_buf_reg  <= fifo_dout;
            end else if (in_xfr) begin
                word_cnt_reg <= words_upd;
                perr_cnt_reg <= perr_upd;
                ovr_reg      <= ovr_upd;
            end
            // STATUS and PERR_CNT are snapshots that stay put until the next DONE.
            if (load_status) begin
                status_reg   <= status_next;
                perr_out_reg <= perr_upd;
            end
            if (fifo_push && fifo_full && !fifo_pop) begin
                drop_cnt_reg <= sat_inc8(drop_cnt_reg);
            end
        end
    end

    assign XFR_START = (state_reg == ST_START);
    assign RCV_EN    = in_xfr;
    assign DONE      = (state_reg == ST_FIN);
    assign XFR_BUF   = xfr_buf_reg;
    assign STATUS    = status_reg;
    assign PERR_CNT  = perr_out_reg;
    assign DROP_CNT  = drop_cnt_reg;

endmodule

// File: tb/tb_rd_xfr_ctrl.sv
// Self-checking bench for rd_xfr_ctrl: an RD link responder drives busy/word
// strobes, a monitor logs pulses and DONE reports, tasks compare to a model.
module tb_rd_xfr_ctrl;

    localparam int XFR_WORDS = 2048;
    localparam int QDEPTH    = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        trigger;
    logic [1:0]  trig_buf;
    logic        rd_busy;
    logic        word_stb;
    logic        parity_err;
    logic        xfr_start;
    logic [1:0]  xfr_buf;
    logic        rcv_en;
    logic        done;
    logic [15:0] status;
    logic [7:0]  perr_cnt;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    always #4 clk = ~clk;

    rd_xfr_ctrl dut (
        .CLK120     (clk),
        .RESETN     (resetn),
        .ENABLE     (enable),
        .TRIGGER    (trigger),
        .TRIG_BUF   (trig_buf),
        .RD_BUSY    (rd_busy),
        .WORD_STB   (word_stb),
        .PARITY_ERR (parity_err),
        .XFR_START  (xfr_start),
        .XFR_BUF    (xfr_buf),
        .RCV_EN     (rcv_en),
        .DONE       (done),
        .STATUS     (status),
        .PERR_CNT   (perr_cnt),
        .DROP_CNT   (drop_cnt)
    );

    // ---------------- monitor: samples 1 time unit after each rising edge
    int          cyc        = 0;
    int          done_cnt   = 0;
    int          start_cnt  = 0;
    int          cur_width  = 0;
    logic        prev_start = 1'b0;
    bit          rcv_seen   = 1'b0;
    int          width_q[$];
    int          rise_q[$];
    int          done_cyc_q[$];
    logic [15:0] stat_q[$];
    logic [7:0]  perr_q[$];
    logic [1:0]  buf_q[$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (xfr_start) begin
                if (!prev_start) begin
                    start_cnt++;
                    rise_q.push_back(cyc);
                    cur_width = 0;
                end
                cur_width++;
            end else if (prev_start) begin
                width_q.push_back(cur_width);
            end
            prev_start = xfr_start;
            if (rcv_en) rcv_seen = 1'b1;
            if (done) begin
                done_cnt++;
                stat_q.push_back(status);
                perr_q.push_back(perr_cnt);
                buf_q.push_back(xfr_buf);
                done_cyc_q.push_back(cyc);
            end
        end
    end

    // ---------------- RD link responder
    bit   rsp_never  = 1'b0;
    bit   rsp_abort  = 1'b0;
    bit   rsp_active = 1'b0;
    logic rsp_prev   = 1'b0;
    int   rsp_delay  = 10;
    int   rsp_words  = 0;
    int   rsp_hold   = 0;
    bit   rsp_perr[4096];

    initial begin
        rd_busy    = 1'b0;
        word_stb   = 1'b0;
        parity_err = 1'b0;
        forever begin
            @(negedge clk);
            if (xfr_start && !rsp_prev && !rsp_never) begin
                rsp_active = 1'b1;
                for (int i = 0; i < rsp_delay && !rsp_abort; i++) @(negedge clk);
                rd_busy = 1'b1;
                for (int i = 0; i < 64 && !rcv_en && !rsp_abort; i++) @(negedge clk);
                if (rsp_hold > 0) begin
                    for (int i = 0; i < rsp_hold - 1 && !rsp_abort; i++) @(negedge clk);
                end else begin
                    for (int i = 0; i < rsp_words && !rsp_abort; i++) begin
                        word_stb   = 1'b1;
                        parity_err = rsp_perr[i];
                        @(negedge clk);
                    end
                end
                word_stb   = 1'b0;
                parity_err = 1'b0;
                rd_busy    = 1'b0;
                rsp_active = 1'b0;
            end
            rsp_prev = xfr_start;
        end
    end

    // ---------------- helpers (stimulus / bounded waits)
    task automatic pulse_trigger(input logic [1:0] b);
        @(negedge clk);
        trigger  = 1'b1;
        trig_buf = b;
        @(negedge clk);
        trigger  = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget, input string what);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            failures++;
            $display("FAIL %s_wait: done count %0d, required %0d within %0d cycles",
                     what, done_cnt, target, budget);
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 200 && rsp_active; i++) @(negedge clk);
        repeat (8) @(negedge clk);
    endtask

    task automatic clear_logs();
        width_q.delete();
        rise_q.delete();
        done_cyc_q.delete();
        stat_q.delete();
        perr_q.delete();
        buf_q.delete();
        rcv_seen = 1'b0;
    endtask

    task automatic set_perr(input int n_err, input int n_words);
        for (int i = 0; i < 4096; i++) rsp_perr[i] = 1'b0;
        for (int k = 0; k < n_err; k++) begin
            int idx;
            do idx = $urandom_range(0, n_words - 1); while (rsp_perr[idx]);
            rsp_perr[idx] = 1'b1;
        end
    endtask

    // ---------------- tests
    task automatic test_reset();
        resetn = 1'b0; enable = 1'b0; trigger = 1'b0; trig_buf = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({xfr_start, xfr_buf, rcv_en, done, status, perr_cnt, drop_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: start=%b buf=%0d rcv=%b done=%b status=%h perr=%0d drop=%0d, required all 0",
                     xfr_start, xfr_buf, rcv_en, done, status, perr_cnt, drop_cnt);
        end
        resetn = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (start_cnt != 0 || done_cnt != 0) begin
            failures++;
            $display("FAIL reset_idle: starts=%0d dones=%0d, required 0 0", start_cnt, done_cnt);
        end
    endtask

    task automatic test_nominal();
        int d0 = done_cnt;
        clear_logs();
        rsp_delay = 10; rsp_words = XFR_WORDS; rsp_hold = 0;
        set_perr(0, 1);
        pulse_trigger(2'd2);
        wait_dones(d0 + 1, 3000, "nominal");
        settle();
        checks++;
        if (done_cnt != d0 + 1) begin failures++; $display("FAIL nominal_done_count: got %0d, required %0d", done_cnt - d0, 1); end
        checks++;
        if (width_q[0] != 4) begin failures++; $display("FAIL nominal_start_width: got %0d, required 4", width_q[0]); end
        checks++;
        if (buf_q[0] !== 2'd2) begin failures++; $display("FAIL nominal_buf: got %0d, required 2", buf_q[0]); end
        checks++;
        if (stat_q[0] !== 16'h0800) begin failures++; $display("FAIL nominal_status: got %h, required 0800", stat_q[0]); end
        checks++;
        if (perr_q[0] !== 8'd0) begin failures++; $display("FAIL nominal_perr: got %0d, required 0", perr_q[0]); end
        checks++;
        if (status !== 16'h0800) begin failures++; $display("FAIL nominal_status_held: got %h, required 0800", status); end
    endtask

    task automatic test_start_tmo();
        int d0 = done_cnt;
        clear_logs();
        rsp_never = 1'b1;
        pulse_trigger(2'($urandom_range(0, 3)));
        wait_dones(d0 + 1, 4400, "start_tmo");
        settle();
        rsp_never = 1'b0;
        checks++;
        if (done_cyc_q[0] - rise_q[0] != 4096) begin
            failures++;
            $display("FAIL start_tmo_latency: got %0d cycles, required 4096", done_cyc_q[0] - rise_q[0]);
        end
        checks++;
        if (stat_q[0][15] !== 1'b1 || stat_q[0][11:0] !== 12'd0) begin
            failures++;
            $display("FAIL start_tmo_status: got %h, required bit15=1 words=0", stat_q[0]);
        end
        checks++;
        if (rcv_seen) begin failures++; $display("FAIL start_tmo_rcv_en: got 1, required never 1"); end
    endtask

    task automatic test_short_parity();
        int d0 = done_cnt;
        clear_logs();
        rsp_delay = 7; rsp_words = 100; rsp_hold = 0;
        set_perr(3, 100);
        pulse_trigger(2'd1);
        wait_dones(d0 + 1, 400, "short");
        settle();
        checks++;
        if (stat_q[0] !== 16'h2064) begin failures++; $display("FAIL short_status: got %h, required 2064", stat_q[0]); end
        checks++;
        if (perr_q[0] !== 8'd3) begin failures++; $display("FAIL short_perr: got %0d, required 3", perr_q[0]); end
    endtask

    task automatic test_overflow();
        int         d0 = done_cnt;
        logic [1:0] model_q[$];
        logic [1:0] exp_bufs[$];
        int         exp_drops = 0;
        logic [7:0] drop0 = drop_cnt;
        logic [1:0] b;
        clear_logs();
        rsp_delay = 5; rsp_words = 40; rsp_hold = 0;
        set_perr(0, 1);
        b = 2'($urandom_range(0, 3));
        exp_bufs.push_back(b);
        pulse_trigger(b);
        for (int k = 0; k < 6; k++) begin
            b = 2'($urandom_range(0, 3));
            if (model_q.size() < QDEPTH) model_q.push_back(b);
            else exp_drops++;
            pulse_trigger(b);
        end
        foreach (model_q[i]) exp_bufs.push_back(model_q[i]);
        wait_dones(d0 + exp_bufs.size(), 800, "overflow");
        settle();
        checks++;
        if (done_cnt - d0 != exp_bufs.size()) begin
            failures++;
            $display("FAIL overflow_done_count: got %0d, required %0d", done_cnt - d0, exp_bufs.size());
        end
        foreach (exp_bufs[i]) begin
            checks++;
            if (buf_q[i] !== exp_bufs[i]) begin
                failures++;
                $display("FAIL overflow_buf_order[%0d]: got %0d, required %0d", i, buf_q[i], exp_bufs[i]);
            end
        end
        checks++;
        if (drop_cnt !== drop0 + 8'(exp_drops)) begin
            failures++;
            $display("FAIL overflow_drop_cnt: got %0d, required %0d", drop_cnt, drop0 + 8'(exp_drops));
        end
        checks++;
        if (rise_q[1] - done_cyc_q[0] != 2) begin
            failures++;
            $display("FAIL back_to_back_gap: got %0d cycles, required 2", rise_q[1] - done_cyc_q[0]);
        end
    endtask

    task automatic test_overrun();
        int d0 = done_cnt;
        clear_logs();
        rsp_delay = 6; rsp_words = XFR_WORDS + 2; rsp_hold = 0;
        set_perr(0, 1);
        pulse_trigger(2'd3);
        wait_dones(d0 + 1, 3000, "overrun");
        settle();
        checks++;
        if (stat_q[0] !== 16'h1800) begin failures++; $display("FAIL overrun_status: got %h, required 1800", stat_q[0]); end
    endtask

    task automatic test_simul_end();
        int d0 = done_cnt;
        clear_logs();
        rsp_delay = 10; rsp_words = 0; rsp_hold = 65535;
        pulse_trigger(2'd0);
        wait_dones(d0 + 1, 66000, "simul_end");
        settle();
        rsp_hold = 0;
        checks++;
        if (stat_q[0][15:14] !== 2'b01 || stat_q[0][11:0] !== 12'd0) begin
            failures++;
            $display("FAIL simul_end_status: got %h, required bit14=1 bit15=0 words=0", stat_q[0]);
        end
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL simul_end_done_count: got %0d, required 1", done_cnt - d0); end
    endtask

    task automatic test_abort();
        int         d0;
        int         s0;
        logic [7:0] drop0;
        int         n = 0;
        clear_logs();
        rsp_delay = 5; rsp_words = 200; rsp_hold = 0;
        set_perr(0, 1);
        d0 = done_cnt;
        drop0 = drop_cnt;
        pulse_trigger(2'd1);
        while (!rcv_en && n < 100) begin @(negedge clk); n++; end
        pulse_trigger(2'd2);
        pulse_trigger(2'd3);
        repeat (5) @(negedge clk);
        enable    = 1'b0;
        rsp_abort = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rcv_en !== 1'b0 || xfr_start !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_next_cycle: rcv=%b start=%b done=%b, required 0 0 0", rcv_en, xfr_start, done);
        end
        settle();
        rsp_abort = 1'b0;
        s0 = start_cnt;
        enable = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin failures++; $display("FAIL abort_no_done: got %0d dones, required 0", done_cnt - d0); end
        checks++;
        if (start_cnt != s0) begin failures++; $display("FAIL abort_queue_flushed: got %0d starts, required 0", start_cnt - s0); end
        checks++;
        if (drop_cnt !== drop0) begin failures++; $display("FAIL abort_drop_kept: got %0d, required %0d", drop_cnt, drop0); end
        rsp_words = 10;
        pulse_trigger(2'd2);
        wait_dones(d0 + 1, 200, "abort_restart");
        settle();
        checks++;
        if (buf_q.size() != 1 || buf_q[0] !== 2'd2) begin
            failures++;
            $display("FAIL abort_restart_buf: got %0d reports buf %0d, required 1 report buf 2", buf_q.size(), buf_q[0]);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int          d0 = done_cnt;
            int          n;
            int          n_err = 0;
            int          exp_words;
            logic [15:0] exp_stat;
            logic [1:0]  b;
            clear_logs();
            b         = 2'($urandom_range(0, 3));
            n         = $urandom_range(0, 80);
            rsp_delay = $urandom_range(1, 20);
            rsp_words = n;
            rsp_hold  = 0;
            for (int i = 0; i < 4096; i++) rsp_perr[i] = 1'b0;
            for (int i = 0; i < n; i++) begin
                rsp_perr[i] = ($urandom_range(0, 3) == 0);
                if (rsp_perr[i]) n_err++;
            end
            exp_words = (n > XFR_WORDS) ? XFR_WORDS : n;
            exp_stat  = {2'b00, (n < XFR_WORDS), (n > XFR_WORDS), 12'(exp_words)};
            pulse_trigger(b);
            wait_dones(d0 + 1, 300, "random");
            settle();
            checks++;
            if (stat_q[0] !== exp_stat || perr_q[0] !== 8'(n_err) || buf_q[0] !== b || width_q[0] != 4) begin
                failures++;
                $display("FAIL random[%0d]: status=%h perr=%0d buf=%0d width=%0d, required %h %0d %0d 4",
                         t, stat_q[0], perr_q[0], buf_q[0], width_q[0], exp_stat, n_err, b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_start_tmo();
        test_short_parity();
        test_overflow();
        test_overrun();
        test_random();
        test_abort();
        test_simul_end();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
